// File: rtl/bus_trace_streamer.sv
// Debug-bus write tracer: captures writes that hit an address window into a FIFO
// and streams each one out as a 9-byte frame (sync, addr MSB first, data MSB first).
module bus_trace_streamer #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     debug_we,
  input  logic [31:0]              debug_addr,
  input  logic [31:0]              debug_data,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  input  logic                     clr_ovf,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [3:0]  LAST_IDX   = 4'd8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state, state_d;
  logic [63:0]  mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, level;
  logic [63:0]  shreg, shreg_d;
  logic [3:0]   idx, idx_d;
  logic         tx_valid_d;
  logic [7:0]   tx_data_d;
  logic         match, push, pop, drop;

  // Pointers carry one extra bit so full (MSBs differ) and empty (equal) are distinct.
  assign level      = wr_ptr - rd_ptr;
  assign fifo_level = level;

  assign match = debug_we && ((debug_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  assign push  = match && ((level != FULL_LEVEL) || pop);
  assign drop  = match && !push;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    shreg_d    = shreg;
    idx_d      = idx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          shreg_d    = mem[rd_ptr[AW-1:0]];
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          idx_d      = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx == LAST_IDX) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            // Byte after the sync is the top byte of {addr,data}; shift left per byte.
            idx_d     = idx + 4'd1;
            tx_data_d = shreg[63:56];
            shreg_d   = {shreg[55:0], 8'h00};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      shreg    <= '0;
      idx      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      shreg    <= shreg_d;
      idx      <= idx_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Clear and drop in the same cycle: clear first, then the drop counts once.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf)                  drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  // NOTE: FIFO storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {debug_addr, debug_data};
  end

endmodule

// File: tb/tb_bus_trace_streamer.sv
// Directed bench for bus_trace_streamer: frame format, stalls, address window,
// overflow/drop counting, full-FIFO pop+push, clear priority and mid-frame reset.
module tb_bus_trace_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        debug_we;
  logic [31:0] debug_addr, debug_data;
  logic        tx_ready, clr_ovf;

  logic        tx_valid, overflow;
  logic [7:0]  tx_data;
  logic [15:0] drop_cnt;
  logic [4:0]  fifo_level;

  logic        tx_valid_w, overflow_w;
  logic [7:0]  tx_data_w;
  logic [15:0] drop_cnt_w;
  logic [4:0]  fifo_level_w;

  int checks   = 0;
  int failures = 0;
  logic [7:0]  got[$];
  logic [31:0] ready_pat = 32'b1011_0010_0110_1001_1100_0101_0011_1010;

  always #5 clk = ~clk;

  bus_trace_streamer dut (
    .clk(clk), .rst(rst), .debug_we(debug_we), .debug_addr(debug_addr),
    .debug_data(debug_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .clr_ovf(clr_ovf), .overflow(overflow),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  bus_trace_streamer #(.ADDR_BASE(32'h4000_0000), .ADDR_MASK(32'hF000_0000)) dut_win (
    .clk(clk), .rst(rst), .debug_we(debug_we), .debug_addr(debug_addr),
    .debug_data(debug_data), .tx_valid(tx_valid_w), .tx_data(tx_data_w),
    .tx_ready(tx_ready), .clr_ovf(clr_ovf), .overflow(overflow_w),
    .drop_cnt(drop_cnt_w), .fifo_level(fifo_level_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] frame_of(input logic [31:0] a, input logic [31:0] d);
    return {8'hA5, a, d};
  endfunction

  function automatic logic [71:0] got_frame(input int k);
    logic [71:0] f = '0;
    for (int b = 0; b < 9; b++) f = {f[63:0], got[k*9 + b]};
    return f;
  endfunction

  task automatic do_reset();
    rst = 1'b1; debug_we = 1'b0; debug_addr = '0; debug_data = '0;
    clr_ovf = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    debug_we = 1'b1; debug_addr = a; debug_data = d;
    tick();
    debug_we = 1'b0;
  endtask

  // Gathers n accepted bytes from one DUT; checks output stability on every stall.
  task automatic collect(input bit win, input int n, input int budget,
                         input bit stall_mode, output int cycles);
    logic v, hold;
    logic [7:0] d, held;
    got.delete();
    cycles = 0;
    hold = 1'b0;
    held = '0;
    while (got.size() < n && cycles < budget) begin
      v = win ? tx_valid_w : tx_valid;
      d = win ? tx_data_w : tx_data;
      if (v && tx_ready) got.push_back(d);
      else if (v) begin hold = 1'b1; held = d; end
      tick();
      cycles++;
      if (hold) begin
        v = win ? tx_valid_w : tx_valid;
        d = win ? tx_data_w : tx_data;
        checks++;
        if (v !== 1'b1 || d !== held) begin
          failures++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", v, d, held);
        end
        hold = 1'b0;
      end
      if (stall_mode) tx_ready = ready_pat[cycles % 32];
    end
    checks++;
    if (got.size() != n) begin
      failures++;
      $display("FAIL collect_timeout: got %0d bytes expected %0d", got.size(), n);
    end
  endtask

  task automatic check_frame(input string name, input int k, input logic [71:0] exp);
    logic [71:0] f;
    checks++;
    if (got.size() < (k + 1) * 9) begin
      failures++;
      $display("FAIL %s: frame %0d missing, got %0d bytes", name, k, got.size());
    end else begin
      f = got_frame(k);
      if (f !== exp) begin
        failures++;
        $display("FAIL %s: frame %0d got %h expected %h", name, k, f, exp);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check_val("rst_fifo_level", 32'(fifo_level), 32'd0);
    check_val("rst_win_drop", 32'({overflow_w, drop_cnt_w}), 32'd0);
  endtask

  task automatic test_basic();
    int cyc;
    do_reset();
    tx_ready = 1'b1;
    write(32'h1000_0004, 32'hDEAD_BEEF);
    check_val("lat_level_n1", 32'(fifo_level), 32'd1);
    check_val("lat_valid_n1", 32'(tx_valid), 32'd0);
    tick();
    check_val("lat_valid_n2", 32'(tx_valid), 32'd1);
    check_val("lat_sync_n2", 32'(tx_data), 32'h0000_00A5);
    check_val("lat_level_n2", 32'(fifo_level), 32'd0);
    collect(1'b0, 9, 50, 1'b0, cyc);
    check_frame("basic_frame", 0, 72'hA5_1000_0004_DEAD_BEEF);
    check_val("basic_cycles", 32'(cyc), 32'd9);
    check_val("basic_valid_end", 32'(tx_valid), 32'd0);
  endtask

  task automatic test_stall();
    int cyc;
    do_reset();
    write(32'h1000_0004, 32'hDEAD_BEEF);
    collect(1'b0, 9, 200, 1'b1, cyc);
    check_frame("stall_frame", 0, frame_of(32'h1000_0004, 32'hDEAD_BEEF));
    tx_ready = 1'b0;
  endtask

  task automatic test_window();
    int cyc, vcount;
    do_reset();
    tx_ready = 1'b1;
    write(32'h4000_0010, 32'h1122_3344);
    write(32'h1000_0000, 32'h5566_7788);
    collect(1'b1, 9, 30, 1'b0, cyc);
    check_frame("window_frame", 0, frame_of(32'h4000_0010, 32'h1122_3344));
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_valid_w) vcount++;
      tick();
    end
    check_val("window_no_extra", 32'(vcount), 32'd0);
    check_val("window_level", 32'(fifo_level_w), 32'd0);
    check_val("window_no_drop", 32'(overflow_w), 32'd0);
  endtask

  // First write occupies the shift register, so the 20 that follow fill 16 and drop 4.
  task automatic test_overflow();
    do_reset();
    write(32'h3000_0000, 32'h0BAD_F00D);
    tick();
    for (int i = 0; i < 20; i++) begin
      debug_we = 1'b1;
      debug_addr = 32'h2000_0000 + 32'(i * 4);
      debug_data = 32'h1111_0000 + 32'(i);
      tick();
    end
    debug_we = 1'b0;
    check_val("ovf_level", 32'(fifo_level), 32'd16);
    check_val("ovf_flag", 32'(overflow), 32'd1);
    check_val("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
    check_val("ovf_stalled_sync", 32'({tx_valid, tx_data}), 32'h0000_01A5);
  endtask

  task automatic test_full_pop_push();
    int cyc;
    tx_ready = 1'b1;
    collect(1'b0, 9, 40, 1'b0, cyc);
    check_frame("pre_frame", 0, frame_of(32'h3000_0000, 32'h0BAD_F00D));
    check_val("full_idle_valid", 32'(tx_valid), 32'd0);
    check_val("full_idle_level", 32'(fifo_level), 32'd16);
    write(32'h2000_0100, 32'h7777_7777);
    check_val("full_pp_level", 32'(fifo_level), 32'd16);
    check_val("full_pp_drop_cnt", 32'(drop_cnt), 32'd4);
    check_val("full_pp_valid", 32'(tx_valid), 32'd1);
    collect(1'b0, 153, 400, 1'b0, cyc);
    for (int k = 0; k < 16; k++)
      check_frame("order_frame", k, frame_of(32'h2000_0000 + 32'(k * 4), 32'h1111_0000 + 32'(k)));
    check_frame("order_frame", 16, frame_of(32'h2000_0100, 32'h7777_7777));
    check_val("b2b_cycles", 32'(cyc), 32'd169);
  endtask

  task automatic test_clear();
    tx_ready = 1'b0;
    write(32'h3000_0004, 32'h0000_0001);
    tick();
    for (int i = 0; i < 16; i++) write(32'h2100_0000 + 32'(i), 32'(i));
    check_val("clr_pre_level", 32'(fifo_level), 32'd16);
    check_val("clr_pre_drop", 32'(drop_cnt), 32'd4);
    clr_ovf = 1'b1;
    write(32'h2200_0000, 32'hFFFF_FFFF);
    clr_ovf = 1'b0;
    check_val("clr_drop_ovf", 32'(overflow), 32'd1);
    check_val("clr_drop_cnt", 32'(drop_cnt), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_val("clr_only", 32'({overflow, drop_cnt}), 32'd0);
  endtask

  task automatic test_reset_mid_frame();
    int cyc, vcount;
    do_reset();
    tx_ready = 1'b1;
    write(32'h0000_00F0, 32'hCAFE_F00D);
    write(32'h0000_00F4, 32'h1234_5678);
    collect(1'b0, 4, 20, 1'b0, cyc);
    check_frame_partial: begin
      check_val("mid_bytes", 32'({got[0], got[1], got[2], got[3]}), 32'hA500_0000);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_valid", 32'(tx_valid), 32'd0);
    check_val("mid_rst_level", 32'(fifo_level), 32'd0);
    write(32'h0000_0ABC, 32'h0BEE_F123);
    collect(1'b0, 9, 30, 1'b0, cyc);
    check_frame("fresh_frame", 0, frame_of(32'h0000_0ABC, 32'h0BEE_F123));
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) vcount++;
      tick();
    end
    check_val("mid_no_resume", 32'(vcount), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_window();
    test_overflow();
    test_full_pop_push();
    test_clear();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
